// File: rtl/conv_drv_pkg.sv
// Shared types and helpers for the conv engine stream driver.
package conv_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of valid-mode convolution outputs for a given X/F length.
  function automatic int calc_y_size(input int x_size, input int f_size);
    return x_size - f_size + 1;
  endfunction

endpackage

// File: rtl/conv_stream_driver_stream_tx.sv
// One outbound valid/ready stream: walks a local memory from element 0 to DEPTH-1.
module stream_tx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       launch,
  input  logic                       ready,
  output logic [$clog2(DEPTH)-1:0]   rd_addr,
  input  logic [WIDTH-1:0]           rd_data,
  output logic                       valid,
  output logic [WIDTH-1:0]           data,
  output logic                       complete
);

  localparam int IW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  // idx counts elements already transferred; it is one wider than the
  // address so that reaching DEPTH is detectable without wrapping.
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;

  assign idx_next = idx + 1'b1;
  assign rd_addr  = launch ? '0 : idx_next[AW-1:0];
  assign complete = (idx == IW'(DEPTH));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx   <= '0;
      valid <= 1'b0;
      data  <= '0;
    end else if (launch) begin
      idx   <= '0;
      valid <= 1'b1;
      data  <= rd_data;
    end else if (valid && ready) begin
      idx <= idx_next;
      if (idx_next == IW'(DEPTH)) begin
        valid <= 1'b0;
      end else begin
        data <= rd_data;
      end
    end
  end

endmodule

// File: rtl/conv_stream_driver.sv
// Stimulus/capture front end for the conv engine: streams F and X out, collects Y.
module conv_stream_driver
  import conv_drv_pkg::*;
#(
  parameter int  DATA_WIDTH_X = 8,
  parameter int  DATA_WIDTH_F = 8,
  parameter int  X_SIZE       = 128,
  parameter int  F_SIZE       = 32,
  parameter int  ACC_SIZE     = 21,
  localparam int Y_SIZE       = calc_y_size(X_SIZE, F_SIZE)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          cfg_wr_en,
  input  logic                          cfg_sel,
  input  logic [$clog2(X_SIZE)-1:0]     cfg_addr,
  input  logic [DATA_WIDTH_X-1:0]       cfg_wr_data,
  output logic                          m_valid_x,
  output logic [DATA_WIDTH_X-1:0]       m_data_out_x,
  input  logic                          m_ready_x,
  output logic                          m_valid_f,
  output logic [DATA_WIDTH_F-1:0]       m_data_out_f,
  input  logic                          m_ready_f,
  input  logic                          s_valid_y,
  input  logic [ACC_SIZE-1:0]           s_data_in_y,
  output logic                          s_ready_y,
  input  logic                          y_hold,
  input  logic [$clog2(Y_SIZE)-1:0]     y_rd_addr,
  output logic [ACC_SIZE-1:0]           y_rd_data,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(Y_SIZE+1)-1:0]   y_count
);

  localparam int XAW = $clog2(X_SIZE);
  localparam int FAW = $clog2(F_SIZE);
  localparam int YAW = $clog2(Y_SIZE);
  localparam int YCW = $clog2(Y_SIZE + 1);

  state_t state;
  state_t state_next;

  logic [DATA_WIDTH_X-1:0] xmem [X_SIZE];
  logic [DATA_WIDTH_F-1:0] fmem [F_SIZE];
  logic [ACC_SIZE-1:0]     ybuf [Y_SIZE];

  logic           launch;
  logic           x_complete;
  logic           f_complete;
  logic           y_take;
  logic [XAW-1:0] x_rd_addr;
  logic [FAW-1:0] f_rd_addr;

  assign launch    = (state == IDLE) && start;
  assign busy      = (state == SEND) || (state == DRAIN);
  assign done      = (state == DONE);
  assign s_ready_y = busy && !y_hold && (y_count < YCW'(Y_SIZE));
  assign y_take    = s_valid_y && s_ready_y;
  assign y_rd_data = (int'(y_rd_addr) < Y_SIZE) ? ybuf[y_rd_addr] : '0;

  stream_tx #(.WIDTH(DATA_WIDTH_X), .DEPTH(X_SIZE)) u_tx_x (
    .clk      (clk),
    .reset    (reset),
    .launch   (launch),
    .ready    (m_ready_x),
    .rd_addr  (x_rd_addr),
    .rd_data  (xmem[x_rd_addr]),
    .valid    (m_valid_x),
    .data     (m_data_out_x),
    .complete (x_complete)
  );

  stream_tx #(.WIDTH(DATA_WIDTH_F), .DEPTH(F_SIZE)) u_tx_f (
    .clk      (clk),
    .reset    (reset),
    .launch   (launch),
    .ready    (m_ready_f),
    .rd_addr  (f_rd_addr),
    .rd_data  (fmem[f_rd_addr]),
    .valid    (m_valid_f),
    .data     (m_data_out_f),
    .complete (f_complete)
  );

  // NOTE: the memories carry no reset so they map onto plain RAM/LUT storage;
  // their contents are meaningful only after being written.
  always_ff @(posedge clk) begin
    if (cfg_wr_en && (state == IDLE)) begin
      if (!cfg_sel) begin
        xmem[cfg_addr] <= cfg_wr_data;
      end else if (int'(cfg_addr) < F_SIZE) begin
        fmem[cfg_addr[FAW-1:0]] <= cfg_wr_data[DATA_WIDTH_F-1:0];
      end
    end
    if (y_take) begin
      ybuf[y_count[YAW-1:0]] <= s_data_in_y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      y_count <= '0;
    end else begin
      state <= state_next;
      if (launch) begin
        y_count <= '0;
      end else if (y_take) begin
        y_count <= y_count + 1'b1;
      end
    end
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SEND;
      SEND:    if (x_complete && f_complete) state_next = DRAIN;
      DRAIN:   if (y_count == YCW'(Y_SIZE)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_stream_driver.sv
// Randomized self-checking bench for conv_stream_driver with a behavioural engine model.
module tb_conv_stream_driver;

  localparam int X_SIZE = 128;
  localparam int F_SIZE = 32;
  localparam int Y_SIZE = 97;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cfg_wr_en;
  logic        cfg_sel;
  logic [6:0]  cfg_addr;
  logic [7:0]  cfg_wr_data;
  logic        m_valid_x;
  logic [7:0]  m_data_out_x;
  logic        m_ready_x;
  logic        m_valid_f;
  logic [7:0]  m_data_out_f;
  logic        m_ready_f;
  logic        s_valid_y;
  logic [20:0] s_data_in_y;
  logic        s_ready_y;
  logic        y_hold;
  logic [6:0]  y_rd_addr;
  logic [20:0] y_rd_data;
  logic        busy;
  logic        done;
  logic [6:0]  y_count;

  int errors = 0;
  int checks = 0;

  int xm [X_SIZE];
  int fm [F_SIZE];

  always #5 clk = ~clk;

  conv_stream_driver dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_sel      (cfg_sel),
    .cfg_addr     (cfg_addr),
    .cfg_wr_data  (cfg_wr_data),
    .m_valid_x    (m_valid_x),
    .m_data_out_x (m_data_out_x),
    .m_ready_x    (m_ready_x),
    .m_valid_f    (m_valid_f),
    .m_data_out_f (m_data_out_f),
    .m_ready_f    (m_ready_f),
    .s_valid_y    (s_valid_y),
    .s_data_in_y  (s_data_in_y),
    .s_ready_y    (s_ready_y),
    .y_hold       (y_hold),
    .y_rd_addr    (y_rd_addr),
    .y_rd_data    (y_rd_data),
    .busy         (busy),
    .done         (done),
    .y_count      (y_count)
  );

  // Valid-mode correlation sum of result k from the model memories.
  function automatic int exp_y(input int k);
    int s = 0;
    for (int j = 0; j < F_SIZE; j++) s += xm[k + j] * fm[j];
    return s;
  endfunction

  task automatic write_cfg(input bit sel, input int addr, input int data);
    @(negedge clk);
    cfg_wr_en   = 1'b1;
    cfg_sel     = sel;
    cfg_addr    = 7'(addr);
    cfg_wr_data = 8'(data);
    @(posedge clk);
    #1 cfg_wr_en = 1'b0;
  endtask

  task automatic load_memories(input bit random_data);
    for (int i = 0; i < X_SIZE; i++) begin
      xm[i] = random_data ? int'($urandom_range(0, 255)) - 128 : i - 64;
      write_cfg(1'b0, i, xm[i]);
    end
    for (int j = 0; j < F_SIZE; j++) begin
      fm[j] = random_data ? int'($urandom_range(0, 255)) - 128 : 1;
      write_cfg(1'b1, j, fm[j]);
    end
  endtask

  // One run with an engine model on the far side of the streams.
  task automatic run_case(input string name, input int stall_pct, input bit late_y,
                          input bit hold_toggle, input int extra, input int reset_at,
                          input bit poke);
    int         x_rx = 0;
    int         f_rx = 0;
    int         y_sent = 0;
    int         dones = 0;
    int         post = 0;
    int         cyc = 0;
    bit         px_stall = 1'b0;
    bit         pf_stall = 1'b0;
    logic [7:0] px_data = '0;
    logic [7:0] pf_data = '0;
    logic [7:0] tmp;
    logic [20:0] exp_val;
    bit         avail;

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    while (post < 6 && cyc < 4000) begin
      @(negedge clk);
      start     = 1'b0;
      cfg_wr_en = 1'b0;
      m_ready_x = int'($urandom_range(0, 99)) >= stall_pct;
      m_ready_f = int'($urandom_range(0, 99)) >= stall_pct;
      if (poke && cyc == 20) begin
        start = 1'b1; cfg_wr_en = 1'b1; cfg_sel = 1'b0; cfg_addr = 7'd100;
        tmp = 8'(xm[100]); cfg_wr_data = ~tmp;
      end
      if (poke && cyc == 21) begin
        start = 1'b1; cfg_wr_en = 1'b1; cfg_sel = 1'b1; cfg_addr = 7'd31;
        tmp = 8'(fm[31]); cfg_wr_data = ~tmp;
      end
      if (reset_at > 0 && cyc == reset_at) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({m_valid_x, m_valid_f, m_data_out_x, m_data_out_f, s_ready_y, busy, done, y_count} !== '0) begin
          errors++;
          $display("FAIL %s reset_mid_run: vx=%0b vf=%0b dx=%h df=%h ry=%0b busy=%0b done=%0b y_count=%0d, required all zero",
                   name, m_valid_x, m_valid_f, m_data_out_x, m_data_out_f, s_ready_y, busy, done, y_count);
        end
        @(negedge clk);
        reset = 1'b0; m_ready_x = 1'b0; m_ready_f = 1'b0; s_valid_y = 1'b0; y_hold = 1'b0;
        return;
      end
      y_hold = hold_toggle && x_rx == X_SIZE && f_rx == F_SIZE && ((cyc / 3) % 2 == 1);
      avail = (f_rx == F_SIZE) && (y_sent < Y_SIZE + extra) &&
              ((late_y || y_sent >= Y_SIZE) ? (x_rx == X_SIZE) : (x_rx >= y_sent + F_SIZE));
      s_valid_y   = avail;
      s_data_in_y = (y_sent < Y_SIZE) ? 21'(exp_y(y_sent)) : 21'h0ABCD;
      #1;

      if (px_stall) begin
        checks++;
        if (m_valid_x !== 1'b1 || m_data_out_x !== px_data) begin
          errors++;
          $display("FAIL %s x_hold: valid=%0b data=%h, required valid=1 data=%h", name, m_valid_x, m_data_out_x, px_data);
        end
      end
      if (pf_stall) begin
        checks++;
        if (m_valid_f !== 1'b1 || m_data_out_f !== pf_data) begin
          errors++;
          $display("FAIL %s f_hold: valid=%0b data=%h, required valid=1 data=%h", name, m_valid_f, m_data_out_f, pf_data);
        end
      end
      if (y_hold) begin
        checks++;
        if (s_ready_y !== 1'b0) begin
          errors++;
          $display("FAIL %s y_hold_ready: s_ready_y=%0b, required 0", name, s_ready_y);
        end
      end
      if (m_valid_x && m_ready_x) begin
        checks++;
        if (x_rx >= X_SIZE || m_data_out_x !== 8'(xm[x_rx % X_SIZE])) begin
          errors++;
          $display("FAIL %s x_seq[%0d]: data=%h, required %h", name, x_rx, m_data_out_x, 8'(xm[x_rx % X_SIZE]));
        end
        x_rx++;
      end
      if (m_valid_f && m_ready_f) begin
        checks++;
        if (f_rx >= F_SIZE || m_data_out_f !== 8'(fm[f_rx % F_SIZE])) begin
          errors++;
          $display("FAIL %s f_seq[%0d]: data=%h, required %h", name, f_rx, m_data_out_f, 8'(fm[f_rx % F_SIZE]));
        end
        f_rx++;
      end
      px_stall = m_valid_x && !m_ready_x;
      pf_stall = m_valid_f && !m_ready_f;
      px_data  = m_data_out_x;
      pf_data  = m_data_out_f;
      if (s_valid_y && s_ready_y) y_sent++;
      if (done) dones++;
      if (dones > 0) post++;
      cyc++;
    end

    @(negedge clk);
    m_ready_x = 1'b0; m_ready_f = 1'b0; s_valid_y = 1'b0; y_hold = 1'b0;
    #1;
    checks++;
    if (post < 6) begin
      errors++;
      $display("FAIL %s timeout: done not seen after %0d cycles, required within 4000", name, cyc);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d, required 1", name, dones);
    end
    checks++;
    if (x_rx != X_SIZE || f_rx != F_SIZE) begin
      errors++;
      $display("FAIL %s transfer_counts: x=%0d f=%0d, required %0d %0d", name, x_rx, f_rx, X_SIZE, F_SIZE);
    end
    checks++;
    if (y_count !== 7'(Y_SIZE) || y_sent != Y_SIZE) begin
      errors++;
      $display("FAIL %s y_count: dut=%0d accepted=%0d, required %0d", name, y_count, y_sent, Y_SIZE);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_done: busy=%0b, required 0", name, busy);
    end
    for (int k = 0; k < Y_SIZE; k++) begin
      y_rd_addr = 7'(k);
      exp_val = 21'(exp_y(k));
      #1;
      checks++;
      if (y_rd_data !== exp_val) begin
        errors++;
        $display("FAIL %s ybuf[%0d]: got %h, required %h", name, k, y_rd_data, exp_val);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_valid_x, m_valid_f, m_data_out_x, m_data_out_f, s_ready_y, busy, done, y_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: vx=%0b vf=%0b dx=%h df=%h ry=%0b busy=%0b done=%0b y_count=%0d, required all zero",
               m_valid_x, m_valid_f, m_data_out_x, m_data_out_f, s_ready_y, busy, done, y_count);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_full_run();
    load_memories(1'b0);
    write_cfg(1'b1, 40, 8'h55);  // out-of-range F address must be dropped
    run_case("full_run", 0, 1'b0, 1'b0, 0, 0, 1'b0);
    y_rd_addr = 7'd0;
    #1;
    checks++;
    if (y_rd_data !== 21'h1FF9F0) begin
      errors++;
      $display("FAIL full_run ybuf0: got %0d, required -1552", $signed(y_rd_data));
    end
  endtask

  task automatic test_backpressure();
    load_memories(1'b1);
    run_case("backpressure", 30, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_y_hold();
    run_case("y_hold", 0, 1'b1, 1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_extra_result();
    run_case("extra_result", 20, 1'b0, 1'b0, 1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    run_case("reset_mid", 0, 1'b0, 1'b0, 0, 50, 1'b0);
    run_case("rerun", 0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_busy_ignores();
    run_case("busy_ignores", 0, 1'b0, 1'b0, 0, 0, 1'b1);
    run_case("readback", 10, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_wr_en = 1'b0; cfg_sel = 1'b0; cfg_addr = '0;
    cfg_wr_data = '0; m_ready_x = 1'b0; m_ready_f = 1'b0; s_valid_y = 1'b0;
    s_data_in_y = '0; y_hold = 1'b0; y_rd_addr = '0;
    test_reset();
    test_full_run();
    test_backpressure();
    test_y_hold();
    test_extra_result();
    test_reset_mid_run();
    test_busy_ignores();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_stream_driver.md
Name: conv_stream_driver

Overview:
Stream master/slave counterpart to the convolution engine's input and output interfaces.
- Holds one X vector and one filter vector in local register memories, loaded through a simple config write port.
- On start, transmits F and X to the engine over valid/ready streams and collects all convolution results into a local Y buffer.
- Used as the on-chip stimulus/capture front end for the conv engine in FPGA bring-up and system-level simulation.

Parameters:
DATA_WIDTH_X, 8, X sample width (signed)
DATA_WIDTH_F, 8, filter coefficient width (signed)
X_SIZE, 128, number of X samples per run
F_SIZE, 32, number of filter taps per run
ACC_SIZE, 21, result width (signed)
Y_SIZE, X_SIZE-F_SIZE+1 (97), results expected per run (derived localparam)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  begin a run; honoured only in IDLE
cfg_wr_en  in  1  write local X/F memory; ignored unless IDLE
cfg_sel  in  1  0 = X memory, 1 = F memory
cfg_addr  in  $clog2(X_SIZE)  write address; for F, upper bits must be 0, writes with addr >= F_SIZE are dropped
cfg_wr_data  in  DATA_WIDTH_X  write data (F uses low DATA_WIDTH_F bits)
m_valid_x  out  1  X stream valid
m_data_out_x  out  DATA_WIDTH_X  X stream data
m_ready_x  in  1  X stream ready from engine
m_valid_f  out  1  F stream valid
m_data_out_f  out  DATA_WIDTH_F  F stream data
m_ready_f  in  1  F stream ready from engine
s_valid_y  in  1  result valid from engine
s_data_in_y  in  ACC_SIZE  result data
s_ready_y  out  1  result ready
y_hold  in  1  test throttle; forces s_ready_y low while high
y_rd_addr  in  $clog2(Y_SIZE)  result buffer read address
y_rd_data  out  ACC_SIZE  combinational read of result buffer
busy  out  1  high in SEND or DRAIN
done  out  1  one-cycle pulse when run completes
y_count  out  $clog2(Y_SIZE+1)  results captured in current/last run

Behaviour:
- Transfer on any stream = valid && ready at posedge.
- Reset values: m_valid_x/f = 0, m_data_out_x/f = 0, s_ready_y = 0, busy = 0, done = 0, y_count = 0, FSM = IDLE.
- Memory contents are not reset.
- FSM states:
  - IDLE: on start, go to SEND. x_idx, f_idx and y_count clear to 0; next cycle m_valid_x and m_valid_f rise with element 0.
  - SEND: X and F streams run independently.
    - Each stream holds valid and data stable until transferred.
    - On transfer, the stream advances its index and presents the next element the following cycle, registered, with no bubble: back-to-back transfers are possible at 1 per cycle.
    - After element F_SIZE-1 (F) or X_SIZE-1 (X) transfers, that stream's valid drops and stays low.
    - When both streams are complete, go to DRAIN.
  - DRAIN: collection continues. When y_count reaches Y_SIZE, go to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- Results are accepted in both SEND and DRAIN, because the engine may emit results before X finishes.
  - s_ready_y = busy && !y_hold && (y_count < Y_SIZE), registered-free (combinational from state).
  - Each accepted result is written to ybuf[y_count] and y_count increments.
- Boundaries:
  - start while busy: ignored.
  - cfg_wr_en while busy: ignored.
  - s_valid_y with s_ready_y low: no capture.
  - y_count saturates at Y_SIZE; extra results are never accepted.
  - y_count and ybuf hold after done until the next start.
  - Reset mid-run: immediate return to IDLE, valids drop the next edge, partial results are discarded (y_count = 0).
- Width rules:
  - Data is stored and transmitted bit-exact; there is no arithmetic on the data path.
  - Index counters: x_idx is $clog2(X_SIZE+1) wide so terminal detection does not wrap.

Decomposition:
- Package conv_drv_pkg: state enum (IDLE, SEND, DRAIN, DONE) and a localparam function computing Y_SIZE.
- Sub-module stream_tx (parameters WIDTH, DEPTH): index counter plus valid/data hold register for one outbound stream, instantiated once for X and once for F.
- Memories and Y capture live in the top level.

Test Plan:
1. Load X[i] = i-64 and F[j] = 1, start, m_ready_x = m_ready_f = 1, engine model returns the true sums -> 128 X and 32 F transfers, y_count = 97, done pulses once, ybuf[0] = -1552.
2. Random 30% deassertion of m_ready_x and m_ready_f -> data never changes while valid && !ready, no element skipped or duplicated, and the sequences match memory order.
3. y_hold toggled every 3 cycles during DRAIN -> s_ready_y is low whenever y_hold = 1, no capture while low, final y_count = 97.
4. Engine offers a 98th result -> it is not accepted, y_count stays 97, done still pulses once.
5. Assert reset at cycle 50 of SEND, then rerun -> all outputs are at reset values one edge later, and the second run completes normally with y_count = 97.
6. start and cfg_wr_en pulsed during SEND -> no restart and the memories are unchanged, verified by readback of the transmitted stream.
